instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL: start  input  1  one-cycle pulse; begins a load session when in IDLE.
REQ-004 SHALL: base_addr  input  32  byte address of the first instruction word; sampled on start.
REQ-005 SHALL: len  input  8  number of words to accept; sampled on start; 0 means 256.
REQ-006 SHALL: abort  input  1  terminates the session at the next safe point.
REQ-007 SHALL: in_valid  input  1  instruction fields are valid.
REQ-008 SHALL: in_ready  output  1  loader accepts fields this cycle.
REQ-009 SHALL: Cond  input  4  condition field.
REQ-010 SHALL: Op  input  2  instruction class (00 data-processing, 01 memory, 10 branch, 11 illegal).
REQ-011 SHALL: Funct  input  6  function field.
REQ-012 SHALL: Rn, Rd  input  4 each  register fields.
REQ-013 SHALL: Src2  input  12  operand-2 or offset field.
REQ-014 SHALL: mem_we  output  1  instruction-memory write strobe.
REQ-015 SHALL: mem_addr  output  32  write byte address.
REQ-016 SHALL: mem_wd  output  32  encoded instruction word.
REQ-017 SHALL: mem_ack  input  1  memory has taken the write.
REQ-018 SHALL: busy  output  1  session in progress.
REQ-019 SHALL: done  output  1  one-cycle pulse at session end.
REQ-020 SHALL: err_count  output  8  illegal-Op words rejected in current session, saturating at 255.

Function
REQ-021 SHALL: FSM states IDLE, ACCEPT, WRITE, DONE; IDLE->ACCEPT on start; ACCEPT->WRITE on in_valid&in_ready with legal Op; WRITE->ACCEPT on mem_ack if words remain, else WRITE->DONE; DONE->IDLE unconditionally after one cycle.
REQ-022 SHALL: start is ignored outside IDLE.
REQ-023 SHALL: in_ready = 1 only in ACCEPT; handshake occurs when in_valid & in_ready.
REQ-024 SHALL: encoded word = {Cond, Op, Funct, Rn, Rd, Src2} (31:28, 27:26, 25:20, 19:16, 15:12, 11:0).
REQ-025 SHALL: Op=10 forces bit 25 to 1; all other Funct bits pass unchanged.
REQ-026 SHALL: Op=11 is accepted by the handshake, not written, increments err_count, and does not count toward len.
REQ-027 SHALL: encoded word and address are registered on handshake; mem_we asserts the following cycle (latency 1) and holds with stable mem_addr/mem_wd until mem_ack.
REQ-028 SHALL: mem_ack sampled only in WRITE; mem_ack outside WRITE is ignored.
REQ-029 SHALL: mem_addr starts at base_addr and increments by 4 per acknowledged write, wrapping modulo 2^32.
REQ-030 SHALL: remaining-word counter decrements on each mem_ack; len=0 loads 256.
REQ-031 SHALL: abort in ACCEPT -> DONE next cycle; abort in WRITE is deferred until mem_ack, then -> DONE; abort in IDLE/DONE ignored.
REQ-032 SHALL: abort and handshake in same ACCEPT cycle -> abort wins, word discarded.
REQ-033 SHALL: busy = 1 in ACCEPT and WRITE; done = 1 only in DONE.
REQ-034 SHALL: err_count cleared on start, held through IDLE for readout.

Reset
REQ-035 SHALL: reset low -> state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wd 0, busy 0, done 0, err_count 0, counters 0, immediately and independent of clk.
REQ-036 SHALL: reset mid-WRITE drops mem_we immediately; no partial session resumes after release.

Structure
REQ-037 SHALL: shared package instr_pkg holds state encoding and Op constants OP_DP=00, OP_MEM=01, OP_BR=10, OP_ILL=11.
REQ-038 SHALL: field packing and branch bit forcing live in combinational sub-module instr_pack; FSM, counters and memory port live in instr_loader.

Verification
REQ-039 SHALL: base_addr=0x100, len=1, Cond=E Op=00 Funct=101000 Rn=2 Rd=1 Src2=0x005 -> mem_we at 0x100 with 0xE2821005, done one cycle after mem_ack.
REQ-040 SHALL: Cond=E Op=10 Funct=001111 Rn=F Rd=F Src2=0xFFD -> mem_wd=0xEAFFFFFD.
REQ-041 SHALL: len=2, words Op=11 then two legal -> err_count=1, two writes at base and base+4.
REQ-042 SHALL: base_addr=0xFFFFFFFC, len=2 -> writes at 0xFFFFFFFC then 0x00000000.
REQ-043 SHALL: mem_ack held low 5 cycles with abort pulsed during WRITE -> mem_we/addr/data stable 5 cycles, DONE after ack, no further in_ready.
REQ-044 SHALL: reset asserted during WRITE -> mem_we, busy drop same cycle; after release start begins fresh session at new base_addr.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared definitions for the instruction loader: FSM states, Op classes,
// counter widths and a saturating increment helper.
package instr_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // Remaining-word counter must hold 256 (len = 0 encodes a full 256-word load).
    localparam int unsigned CNT_W = 9;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Packs decoded instruction fields into a 32-bit word; branch class forces bit 25.
module instr_pack
    import instr_pkg::*;
(
    input  logic [3:0]  cond,
    input  logic [1:0]  op,
    input  logic [5:0]  funct,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [11:0] src2,
    output logic [31:0] word
);

    logic [5:0] funct_eff;

    // Field concatenation with the branch-class bit override on Funct[5] (word bit 25).
    always_comb begin
        funct_eff = funct;
        if (op == OP_BR) begin
            funct_eff[5] = 1'b1;
        end
        word = {cond, op, funct_eff, rn, rd, src2};
    end

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: accepts decoded fields over a valid/ready handshake,
// packs them and writes them to instruction memory at consecutive addresses.
module instr_loader
    import instr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [7:0]  len,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  Cond,
    input  logic [1:0]  Op,
    input  logic [5:0]  Funct,
    input  logic [3:0]  Rn,
    input  logic [3:0]  Rd,
    input  logic [11:0] Src2,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic [7:0]  err_count
);

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wd_q, wd_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [7:0]         err_q, err_d;
    logic               abort_pend_q, abort_pend_d;

    logic [31:0]        packed_word;
    logic               hs;
    logic               legal;

    instr_pack u_pack (
        .cond  (Cond),
        .op    (Op),
        .funct (Funct),
        .rn    (Rn),
        .rd    (Rd),
        .src2  (Src2),
        .word  (packed_word)
    );

    assign hs = in_valid && (state_q == S_ACCEPT);

    // Op class legality: only the illegal class is rejected.
    always_comb begin
        legal = 1'b0;
        case (Op)
            OP_DP, OP_MEM, OP_BR: legal = 1'b1;
            OP_ILL:               legal = 1'b0;
            default:              legal = 1'b0;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wd_q         <= '0;
            rem_q        <= '0;
            err_q        <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wd_q         <= wd_d;
            rem_q        <= rem_d;
            err_q        <= err_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    // Next-state logic; an abort seen during WRITE takes effect at the ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_ACCEPT;
            S_ACCEPT: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (hs && legal) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    if (abort_pend_q || abort || (rem_q == CNT_W'(1))) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCEPT;
                    end
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Session counters, write address/data capture and error counting.
    always_comb begin
        addr_d       = addr_q;
        wd_d         = wd_q;
        rem_d        = rem_q;
        err_d        = err_q;
        abort_pend_d = abort_pend_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d       = base_addr;
                    rem_d        = (len == 8'd0) ? CNT_W'(256) : {1'b0, len};
                    err_d        = '0;
                    abort_pend_d = 1'b0;
                end
            end
            S_ACCEPT: begin
                if (hs && !abort) begin
                    if (legal) begin
                        wd_d = packed_word;
                    end else begin
                        err_d = sat_inc8(err_q);
                    end
                end
            end
            S_WRITE: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (mem_ack) begin
                    addr_d       = addr_q + 32'd4;
                    rem_d        = rem_q - CNT_W'(1);
                    abort_pend_d = 1'b0;
                end
            end
            S_DONE:  abort_pend_d = 1'b0;
            default: abort_pend_d = 1'b0;
        endcase
    end

    // Outputs decoded from the registered state; memory port driven from registers.
    always_comb begin
        in_ready  = (state_q == S_ACCEPT);
        mem_we    = (state_q == S_WRITE);
        busy      = (state_q == S_ACCEPT) || (state_q == S_WRITE);
        done      = (state_q == S_DONE);
        mem_addr  = addr_q;
        mem_wd    = wd_q;
        err_count = err_q;
    end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: driver pushes expected writes, monitor checks them.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic [7:0]  len;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Cond;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic [3:0]  Rn;
    logic [3:0]  Rd;
    logic [11:0] Src2;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic [7:0]  err_count;

    logic ack_auto = 1'b1;
    logic ack_man  = 1'b0;
    logic ack_rand = 1'b0;
    assign mem_ack = ack_auto ? ack_rand : ack_man;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t q[$];
    int compared   = 0;
    int mismatched = 0;

    // Reference model of the session
    logic [31:0] addr_m;
    int          left_m;
    int          err_m;
    bit          hung = 1'b0;

    instr_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Cond      (Cond),
        .Op        (Op),
        .Funct     (Funct),
        .Rn        (Rn),
        .Rd        (Rd),
        .Src2      (Src2),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .done      (done),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Expected word from the field layout: Cond|Op|Funct|Rn|Rd|Src2, branch sets Funct MSB.
    function automatic logic [31:0] ref_word(input logic [3:0] c, input logic [1:0] o,
                                              input logic [5:0] f, input logic [3:0] rn,
                                              input logic [3:0] rd, input logic [11:0] s2);
        int unsigned fv;
        int unsigned w;
        fv = f;
        if (o == 2'b10 && fv < 32) fv = fv + 32;
        w = c * 32'h1000_0000 + o * 32'h0400_0000 + fv * 32'h0010_0000
          + rn * 32'h0001_0000 + rd * 32'h0000_1000 + s2;
        return w;
    endfunction

    // Random memory acknowledge, also toggling while no write is pending.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ack_rand = ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor: pops the expected write on each accepted write and checks hold stability.
    bit          prev_we = 1'b0;
    logic [31:0] prev_addr, prev_wd;
    always @(negedge clk) begin
        if (!reset) begin
            prev_we = 1'b0;
        end else if (mem_we) begin
            if (prev_we) begin
                chk("hold_addr", mem_addr, prev_addr);
                chk("hold_wd", mem_wd, prev_wd);
            end
            if (mem_ack) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_write: addr %h data %h with none expected", mem_addr, mem_wd);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wr_addr", mem_addr, e.a);
                    chk("wr_data", mem_wd, e.d);
                end
                prev_we = 1'b0;
            end else begin
                prev_we   = 1'b1;
                prev_addr = mem_addr;
                prev_wd   = mem_wd;
            end
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic start_session(input logic [31:0] b, input logic [7:0] l);
        start     = 1'b1;
        base_addr = b;
        len       = l;
        @(posedge clk); #1;
        start     = 1'b0;
        addr_m    = b;
        left_m    = (l == 8'd0) ? 256 : int'(l);
        err_m     = 0;
    endtask

    task automatic offer(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                         input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] s2);
        bit got;
        got   = 1'b0;
        Cond  = c; Op = o; Funct = f; Rn = rn; Rd = rd; Src2 = s2;
        in_valid = 1'b1;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) begin
            timeout_fail("handshake");
            in_valid = 1'b0;
            hung     = 1'b1;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (o == 2'b11) begin
            err_m = (err_m == 255) ? 255 : err_m + 1;
        end else begin
            q.push_back('{addr_m, ref_word(c, o, f, rn, rd, s2)});
            addr_m = addr_m + 32'd4;
            left_m--;
        end
    endtask

    task automatic finish_check(input string name);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) begin
            timeout_fail(name);
            hung = 1'b1;
        end else begin
            chk({name, "_err"}, 32'(err_count), 32'(err_m));
            chk({name, "_pending"}, 32'(q.size()), 32'd0);
            chk({name, "_busy_in_done"}, 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_done_pulse"}, 32'(done), 32'd0);
        chk({name, "_idle_ready"}, 32'(in_ready), 32'd0);
        chk({name, "_err_held"}, 32'(err_count), 32'(err_m));
        @(posedge clk); #1;
    endtask

    task automatic random_session(input logic [7:0] l, input bit may_abort);
        logic [1:0] o;
        start_session($urandom, l);
        while (left_m > 0 && !hung) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            if (may_abort && $urandom_range(0, 7) == 0) begin
                Cond = 4'($urandom); Op = 2'($urandom); Funct = 6'($urandom);
                Rn = 4'($urandom); Rd = 4'($urandom); Src2 = 12'($urandom);
                in_valid = 1'b1;
                abort    = 1'b1;
                break;
            end
            o = ($urandom_range(0, 5) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            offer(4'($urandom), o, 6'($urandom), 4'($urandom), 4'($urandom), 12'($urandom));
        end
        finish_check("session");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; len = '0; abort = 1'b0;
        in_valid = 1'b0; Cond = '0; Op = '0; Funct = '0; Rn = '0; Rd = '0; Src2 = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // Single data-processing word, manual ack, done right after the ack
        ack_auto = 1'b0;
        start_session(32'h100, 8'd1);
        offer(4'hE, 2'b00, 6'b101000, 4'h2, 4'h1, 12'h005);
        ack_man = 1'b1;
        @(negedge clk);
        chk("t1_we_latency", 32'(mem_we), 32'd1);
        chk("t1_addr", mem_addr, 32'h0000_0100);
        chk("t1_data", mem_wd, 32'hE282_1005);
        @(posedge clk); #1;
        ack_man = 1'b0;
        @(negedge clk);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_we_off", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_done_once", 32'(done), 32'd0);
        @(posedge clk); #1;
        ack_auto = 1'b1;

        // Branch class forces bit 25
        start_session(32'h200, 8'd1);
        offer(4'hE, 2'b10, 6'b001111, 4'hF, 4'hF, 12'hFFD);
        @(negedge clk);
        chk("t2_branch_word", mem_wd, 32'hEAFF_FFFD);
        finish_check("t2");

        // Illegal word skipped, two legal writes follow
        start_session(32'h300, 8'd2);
        offer(4'h1, 2'b11, 6'h3F, 4'h3, 4'h4, 12'h123);
        offer(4'h2, 2'b01, 6'h11, 4'h5, 4'h6, 12'h456);
        offer(4'h3, 2'b00, 6'h22, 4'h7, 4'h8, 12'h789);
        finish_check("t3");

        // Address wrap
        start_session(32'hFFFF_FFFC, 8'd2);
        offer(4'h0, 2'b00, 6'h01, 4'h1, 4'h2, 12'h003);
        offer(4'h0, 2'b01, 6'h02, 4'h3, 4'h4, 12'h005);
        finish_check("t4");

        // Deferred abort with a slow memory
        ack_auto = 1'b0;
        start_session(32'h400, 8'd3);
        offer(4'h9, 2'b01, 6'h15, 4'hA, 4'hB, 12'hABC);
        abort = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_we_held", 32'(mem_we), 32'd1);
            chk("t5_addr_held", mem_addr, 32'h0000_0400);
            chk("t5_data_held", mem_wd, ref_word(4'h9, 2'b01, 6'h15, 4'hA, 4'hB, 12'hABC));
            @(posedge clk); #1;
            abort = 1'b0;
        end
        ack_man = 1'b1;
        @(posedge clk); #1;
        ack_man = 1'b0;
        @(negedge clk);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_no_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("t5_stay_idle", 32'(in_ready | busy), 32'd0);
        end
        @(posedge clk); #1;

        // Reset during a pending write, then a fresh session
        start_session(32'h500, 8'd2);
        offer(4'h4, 2'b00, 6'h0C, 4'h1, 4'h1, 12'h111);
        #2 reset = 1'b0;
        q.delete();
        #1;
        chk("t6_we_drop", 32'(mem_we), 32'd0);
        chk("t6_busy_drop", 32'(busy), 32'd0);
        chk("t6_addr_clr", mem_addr, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_no_resume", 32'(busy | mem_we), 32'd0);
        @(posedge clk); #1;
        ack_auto = 1'b1;
        start_session(32'h2000, 8'd1);
        offer(4'h7, 2'b10, 6'h00, 4'h2, 4'h3, 12'h444);
        finish_check("t6");

        // Error counter saturates at 255
        start_session(32'h600, 8'd1);
        for (int i = 0; i < 260 && !hung; i++) begin
            offer(4'($urandom), 2'b11, 6'($urandom), 4'($urandom), 4'($urandom), 12'($urandom));
        end
        chk("sat_err", 32'(err_count), 32'd255);
        abort = 1'b1;
        finish_check("sat");

        // len = 0 loads 256 words
        if (!hung) random_session(8'd0, 1'b0);

        // Randomized sessions with occasional aborts
        for (int s = 0; s < 25 && !hung; s++) begin
            random_session(8'($urandom_range(1, 6)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
